// File: rtl/bch15_5_encoder.sv
// Systematic BCH(15,5) t=3 encoder: 5-bit message in, 15-bit codeword out, parity built serially in a 10-bit LFSR.
// Latency: message accepted at edge T, codeword valid from edge T+5; next message no sooner than T+7.
// Backpressure: codeword held stable in HOLD until out_ready; in_ready stays low from acceptance until the cycle after the handshake.
//
// Ports:
//   clk, rst              rising-edge clock, asynchronous active-high reset
//   msg, in_valid/ready   input message (msg[4] is the coefficient of x^14) and its handshake
//   code, out_valid/ready codeword (code[14:10]=msg, code[9:0]=parity, bit i = coeff of x^i) and its handshake
//   busy                  high while a message is being shifted or held
module bch15_5_encoder #(
    parameter logic [9:0] POLY = 10'h137   // g(x) low coefficients; x^10 implicit
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  msg,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [14:0] code,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;

    logic [4:0]  msg_reg;
    logic [9:0]  parity;
    logic [9:0]  parity_next;
    logic [2:0]  bit_cnt;
    logic        cur_bit;
    logic        fb;

    // One step of division by g(x): the bit leaving parity[9] combined with
    // the incoming message bit decides whether g(x) is subtracted.
    always_comb begin
        cur_bit     = msg_reg[bit_cnt];
        fb          = cur_bit ^ parity[9];
        parity_next = {parity[8:0], 1'b0} ^ (fb ? POLY : 10'h000);
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (bit_cnt == 3'd0) begin
                    state_next = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath: message latch, LFSR, bit counter and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            msg_reg   <= 5'd0;
            parity    <= 10'd0;
            bit_cnt   <= 3'd0;
            code      <= 15'd0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        msg_reg <= msg;
                        parity  <= 10'd0;
                        bit_cnt <= 3'd4;   // MSB first
                    end
                end
                SHIFT: begin
                    parity <= parity_next;
                    if (bit_cnt == 3'd0) begin
                        // Last shift: parity_next already holds the full remainder.
                        code      <= {msg_reg, parity_next};
                        out_valid <= 1'b1;
                    end else begin
                        bit_cnt <= bit_cnt - 3'd1;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

    // Decoded from the state register only, so no input-to-output path.
    assign in_ready = (state == IDLE);
    assign busy     = (state != IDLE);

endmodule
